regfile_bypass_param: RTL and testbench
=======================================

Name: regfile_bypass_param

Overview:
- Parametrised successor of the pipeline's 2-read/1-write register file.
- Width and depth are configurable. Register 0 can optionally be hardwired to zero.
- Write-to-read bypass is selectable, so the decode stage sees same-cycle writeback data.
- After reset, the block runs a sequential clear sweep, one entry per cycle, and signals readiness to the pipeline controller.

Parameters:
- DATA_W, 32, data width of each register in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary register.
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to that read port; 0 = the read returns the old contents.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- RS  input  ADDR_W  read address, port 1.
- RT  input  ADDR_W  read address, port 2.
- Data1  output  DATA_W  read data, port 1 (combinational).
- Data2  output  DATA_W  read data, port 2 (combinational).
- write_reg  input  ADDR_W  write address.
- WriteData  input  DATA_W  write data.
- RegW  input  1  write enable.
- ready  output  1  high once the clear sweep has finished.
- write_dropped  output  1  one-cycle pulse when a write is rejected during the sweep.
- issue_valid  input  1  scoreboard only: marks a destination as pending.
- issue_reg  input  ADDR_W  scoreboard only: destination being issued.
- RS_pending  output  1  scoreboard only: pending bit for RS.
- RT_pending  output  1  scoreboard only: pending bit for RT.

Behaviour:
- Reset:
  - The reset cycle sets state to CLEAR, clear_idx to 0, ready to 0 and write_dropped to 0.
  - Array contents are not written during the reset cycle itself.
  - Reset asserted mid-sweep restarts the sweep at index 0.
- FSM has two states, CLEAR and READY:
  - CLEAR: each clock writes 0 to entry clear_idx, then increments clear_idx.
  - When entry DEPTH-1 is written, the next state is READY.
  - ready rises exactly DEPTH clocks after the first clock with reset low; that is 32 cycles at the defaults.
  - READY is held until the next reset.
- Reads during CLEAR:
  - Data1 and Data2 return 0 regardless of array contents.
  - Bypass is disabled.
- Writes during CLEAR:
  - A write with RegW=1 is discarded.
  - write_dropped pulses high for one cycle on the following clock.
  - A write to entry 0 with ZERO_REG=1 is also discarded, but does not pulse write_dropped.
- Writes in READY:
  - When RegW=1, entry write_reg takes WriteData on the rising edge.
  - With ZERO_REG=1 and write_reg=0, the write is ignored and write_dropped stays 0.
- Reads in READY:
  - Data1 = array[RS], Data2 = array[RT], combinational.
  - With ZERO_REG=1, address 0 always returns 0.
- Bypass, when BYPASS=1 in READY:
  - If RegW=1, write_reg==RS and the write is not a suppressed entry-0 write, then Data1 = WriteData in the same cycle.
  - The same rule applies to RT and Data2.
  - Both ports may bypass simultaneously when RS==RT==write_reg.
- Without bypass, when BYPASS=0: a same-cycle read returns the old value; the new value is visible from the next cycle.
- Widths: no arithmetic. The clear_idx counter is ADDR_W+1 bits wide, so a terminal compare at DEPTH-1 cannot wrap.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- When defined:
  - The block adds a DEPTH-bit pending vector and the issue_valid, issue_reg, RS_pending and RT_pending ports.
  - issue_valid=1 sets pending[issue_reg] on the next edge.
  - An accepted write clears pending[write_reg].
  - If set and clear hit the same index in the same cycle, set wins.
  - With ZERO_REG=1, pending[0] stays 0.
  - RS_pending and RT_pending are combinational reads of pending[RS] and pending[RT].
  - When BYPASS=1, a same-cycle clear of the addressed entry forces the pending output to 0.
  - Reset and the CLEAR state hold the whole vector at 0, and issues are ignored.
- When not defined: those four ports and the pending vector are absent. All other behaviour is identical.

Test Plan:
- Sweep timing: reset high 1 cycle, then low -> ready=0 for 32 cycles and 1 on cycle 33; a write of 0xDEADBEEF to r5 at cycle 10 -> write_dropped=1 at cycle 11, and r5 reads 0 after ready.
- Reset mid-sweep: reset asserted again at sweep cycle 20 -> clear_idx restarts at 0, ready rises 32 cycles after that reset deasserts.
- Bypass: in READY, RegW=1, write_reg=7, WriteData=0x12345678, RS=RT=7 -> Data1=Data2=0x12345678 in the same cycle. With BYPASS=0 both ports show the old value, then 0x12345678 the next cycle.
- Entry zero: write 0xFFFFFFFF to r0 with RS=0 -> Data1=0 in the same and next cycle, write_dropped=0. With ZERO_REG=0, r0 reads 0xFFFFFFFF on the next cycle.
- Full depth: write value i*0x01010101 to every entry 1..31, then read all entries on both ports -> every value matches, and entry 0 reads 0.
- Scoreboard (macro on): issue r9 -> RS_pending=1 when RS=9. Writing r9 while issuing r9 in the same cycle -> pending stays 1. Writing r9 alone -> the pending bit clears on the next edge, and RS_pending=0 in the write cycle when BYPASS=1.

Source files
------------

// File: rtl/regfile_bypass_param.sv
// regfile_bypass_param
//   Parametrised 2-read/1-write register file. After reset it clears itself,
//   one entry per clock, and then raises ready.
//   Options:
//     ZERO_REG = 1 : entry 0 reads as zero and ignores writes.
//     BYPASS   = 1 : a same-cycle write is forwarded to a matching read port.
//   Build macro:
//     REGFILE_SCOREBOARD_EN adds a per-entry pending-write scoreboard.
//   Ports:
//     clk, reset           clock and synchronous active-high reset
//     RS, RT               read addresses
//     Data1, Data2         combinational read data
//     write_reg, WriteData write address and data
//     RegW                 write enable
//     ready                clear sweep finished
//     write_dropped        one-cycle pulse after a write rejected by the sweep
//     issue_valid/issue_reg, RS_pending/RT_pending  scoreboard only
//
//   state | meaning
//   CLEAR | sweeping zeros into the array; reads return 0, writes are dropped
//   READY | normal register file operation until the next reset
module regfile_bypass_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegW,
  output logic              ready,
  output logic              write_dropped
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              RS_pending,
  output logic              RT_pending
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  // One extra bit so the terminal compare never aliases with a wrapped count.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_IDX  = (ADDR_W + 1)'(1);

  typedef enum logic {CLEAR, READY} stateT;

  stateT             state, stateNext;
  logic [ADDR_W:0]   clearIdx, clearIdxNext;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              zeroWrite;
  logic              writeAccept;
  logic              dropNext;

  assign zeroWrite   = (ZERO_REG != 0) && (write_reg == '0);
  assign writeAccept = (state == READY) && RegW && !zeroWrite;
  assign dropNext    = (state == CLEAR) && RegW && !zeroWrite;
  assign ready       = (state == READY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= CLEAR;
      clearIdx      <= '0;
      write_dropped <= 1'b0;
    end else begin
      state         <= stateNext;
      clearIdx      <= clearIdxNext;
      write_dropped <= dropNext;
    end
  end

  always_comb begin
    stateNext    = state;
    clearIdxNext = clearIdx;
    case (state)
      CLEAR: begin
        clearIdxNext = clearIdx + ONE_IDX;
        if (clearIdx == LAST_IDX) stateNext = READY;
      end
      READY: begin
        stateNext = READY;
      end
      default: stateNext = CLEAR;
    endcase
  end

  // The array has no reset; the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) mem[clearIdx[ADDR_W-1:0]] <= '0;
      else if (writeAccept) mem[write_reg] <= WriteData;
    end
  end

  always_comb begin
    Data1 = '0;
    if (state == READY) begin
      if ((ZERO_REG != 0) && (RS == '0)) Data1 = '0;
      else if ((BYPASS != 0) && writeAccept && (write_reg == RS)) Data1 = WriteData;
      else Data1 = mem[RS];
    end
  end

  always_comb begin
    Data2 = '0;
    if (state == READY) begin
      if ((ZERO_REG != 0) && (RT == '0)) Data2 = '0;
      else if ((BYPASS != 0) && writeAccept && (write_reg == RT)) Data2 = WriteData;
      else Data2 = mem[RT];
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pending, pendingNext;

  // Clear first, then set, so an issue in the same cycle wins.
  always_comb begin
    pendingNext = pending;
    if (writeAccept) pendingNext[write_reg] = 1'b0;
    if (issue_valid) pendingNext[issue_reg] = 1'b1;
    if (ZERO_REG != 0) pendingNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || (state == CLEAR)) pending <= '0;
    else pending <= pendingNext;
  end

  assign RS_pending = pending[RS] && !((BYPASS != 0) && writeAccept && (write_reg == RS));
  assign RT_pending = pending[RT] && !((BYPASS != 0) && writeAccept && (write_reg == RT));
`endif

endmodule

// File: tb/tb_regfile_bypass_param.sv
// Bench for regfile_bypass_param: three instances (defaults, BYPASS=0,
// ZERO_REG=0) share one stimulus stream and are compared against a
// behavioural model, plus directed sequences and a vector table.
module tb_regfile_bypass_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  RS = '0, RT = '0, write_reg = '0;
  logic [31:0] WriteData = '0;
  logic        RegW = 1'b0;
  logic [31:0] d1 [3];
  logic [31:0] d2 [3];
  logic        rdy [3];
  logic        drp [3];
`ifdef REGFILE_SCOREBOARD_EN
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_reg = '0;
  logic        rsP [3];
  logic        rtP [3];
`endif

  int tests = 0;
  int fails = 0;
  bit checksOn = 1'b0;

  always #5 clk = ~clk;

  regfile_bypass_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut0 (
    .clk(clk), .reset(reset), .RS(RS), .RT(RT), .Data1(d1[0]), .Data2(d2[0]),
    .write_reg(write_reg), .WriteData(WriteData), .RegW(RegW),
    .ready(rdy[0]), .write_dropped(drp[0])
`ifdef REGFILE_SCOREBOARD_EN
    , .issue_valid(issue_valid), .issue_reg(issue_reg), .RS_pending(rsP[0]), .RT_pending(rtP[0])
`endif
  );

  regfile_bypass_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut1 (
    .clk(clk), .reset(reset), .RS(RS), .RT(RT), .Data1(d1[1]), .Data2(d2[1]),
    .write_reg(write_reg), .WriteData(WriteData), .RegW(RegW),
    .ready(rdy[1]), .write_dropped(drp[1])
`ifdef REGFILE_SCOREBOARD_EN
    , .issue_valid(issue_valid), .issue_reg(issue_reg), .RS_pending(rsP[1]), .RT_pending(rtP[1])
`endif
  );

  regfile_bypass_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) dut2 (
    .clk(clk), .reset(reset), .RS(RS), .RT(RT), .Data1(d1[2]), .Data2(d2[2]),
    .write_reg(write_reg), .WriteData(WriteData), .RegW(RegW),
    .ready(rdy[2]), .write_dropped(drp[2])
`ifdef REGFILE_SCOREBOARD_EN
    , .issue_valid(issue_valid), .issue_reg(issue_reg), .RS_pending(rsP[2]), .RT_pending(rtP[2])
`endif
  );

  // ---------------- behavioural model ----------------
  logic [31:0] mMem [3][32];
  bit          mPend [3][32];
  bit          mDrop [3];
  bit          mReady = 1'b0;
  int          mCount = 0;

  function automatic bit zrOf(input int c);
    return c != 2;
  endfunction

  function automatic bit bypOf(input int c);
    return c != 1;
  endfunction

  function automatic bit accepted(input int c);
    return mReady && RegW && !(zrOf(c) && write_reg == 5'd0);
  endfunction

  function automatic logic [31:0] expRead(input int c, input logic [4:0] a);
    if (!mReady) return 32'd0;
    if (zrOf(c) && a == 5'd0) return 32'd0;
    if (bypOf(c) && accepted(c) && write_reg == a) return WriteData;
    return mMem[c][a];
  endfunction

  function automatic bit expPend(input int c, input logic [4:0] a);
    if (bypOf(c) && accepted(c) && write_reg == a) return 1'b0;
    return mPend[c][a];
  endfunction

  task automatic modelEdge();
    bit issueNow = 1'b0;
    logic [4:0] issueAt = '0;
`ifdef REGFILE_SCOREBOARD_EN
    issueNow = issue_valid;
    issueAt  = issue_reg;
`endif
    if (reset) begin
      mReady = 1'b0;
      mCount = 0;
      for (int c = 0; c < 3; c++) begin
        mDrop[c] = 1'b0;
        for (int a = 0; a < 32; a++) mPend[c][a] = 1'b0;
      end
    end else if (!mReady) begin
      mCount++;
      for (int c = 0; c < 3; c++) begin
        mDrop[c] = RegW && !(zrOf(c) && write_reg == 5'd0);
        for (int a = 0; a < 32; a++) mPend[c][a] = 1'b0;
      end
      if (mCount == 32) begin
        mReady = 1'b1;
        for (int c = 0; c < 3; c++)
          for (int a = 0; a < 32; a++) mMem[c][a] = 32'd0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        mDrop[c] = 1'b0;
        if (accepted(c)) begin
          mMem[c][write_reg] = WriteData;
          mPend[c][write_reg] = 1'b0;
        end
        if (issueNow) mPend[c][issueAt] = 1'b1;
        if (zrOf(c)) mPend[c][0] = 1'b0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkBit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    for (int c = 0; c < 3; c++) begin
      chkBit($sformatf("c%0d_ready", c), rdy[c], mReady);
      chkBit($sformatf("c%0d_write_dropped", c), drp[c], mDrop[c]);
      chk($sformatf("c%0d_Data1 rs=%0d", c, RS), d1[c], expRead(c, RS));
      chk($sformatf("c%0d_Data2 rt=%0d", c, RT), d2[c], expRead(c, RT));
`ifdef REGFILE_SCOREBOARD_EN
      chkBit($sformatf("c%0d_RS_pending", c), rsP[c], expPend(c, RS));
      chkBit($sformatf("c%0d_RT_pending", c), rtP[c], expPend(c, RT));
`endif
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; checks happen 3 units
  // after the edge, well before the next one.
  task automatic tick();
    #2;
    if (checksOn) checkAll();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegW = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
    issue_valid = 1'b0;
`endif
  endtask

  typedef struct {
    logic [4:0]  rs, rt, wr;
    logic [31:0] wd;
    logic        regw;
    logic [31:0] e1, e2;   // defaults (bypass on)
    logic [31:0] n1, n2;   // BYPASS=0 instance
  } vecT;

  vecT tbl [6];

  initial begin
    int readyAt;

    tbl[0] = '{5'd7, 5'd7, 5'd7, 32'h12345678, 1'b1, 32'h12345678, 32'h12345678, 32'h07070707, 32'h07070707};
    tbl[1] = '{5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    tbl[2] = '{5'd0, 5'd3, 5'd0, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h03030303, 32'h0, 32'h03030303};
    tbl[3] = '{5'd0, 5'd31, 5'd0, 32'h0, 1'b0, 32'h0, 32'h1F1F1F1F, 32'h0, 32'h1F1F1F1F};
    tbl[4] = '{5'd5, 5'd9, 5'd9, 32'hA5A5A5A5, 1'b1, 32'h05050505, 32'hA5A5A5A5, 32'h05050505, 32'h09090909};
    tbl[5] = '{5'd9, 5'd5, 5'd0, 32'h0, 1'b0, 32'hA5A5A5A5, 32'h05050505, 32'hA5A5A5A5, 32'h05050505};

    // Initial reset; the DUT state before it is unknown, so no checks yet.
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    checksOn = 1'b1;
    reset = 1'b0;

    // Sweep timing, with a write to r5 that must be dropped.
    readyAt = -1;
    for (int n = 1; n <= 40 && readyAt < 0; n++) begin
      RS = 5'd5;
      RT = 5'd0;
      if (n == 10) begin
        RegW = 1'b1;
        write_reg = 5'd5;
        WriteData = 32'hDEADBEEF;
      end else begin
        RegW = 1'b0;
      end
      tick();
      if (n == 10) chkBit("sweep_drop_pulse", drp[0], 1'b1);
      if (n == 11) chkBit("sweep_drop_single", drp[0], 1'b0);
      if (n == 31) chkBit("sweep_not_ready_31", rdy[0], 1'b0);
      if (rdy[0]) readyAt = n;
    end
    chk("sweep_ready_cycle", 32'(readyAt), 32'd32);
    RS = 5'd5;
    #1;
    chk("r5_after_sweep", d1[0], 32'd0);
    tick();

    // Reset in the middle of a sweep restarts it.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 20; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    readyAt = -1;
    for (int n = 1; n <= 40 && readyAt < 0; n++) begin
      tick();
      if (rdy[0]) readyAt = n;
    end
    chk("midsweep_ready_cycle", 32'(readyAt), 32'd32);

    // Full depth fill and readback.
    for (int i = 1; i < 32; i++) begin
      RegW = 1'b1;
      write_reg = 5'(i);
      WriteData = 32'(i) * 32'h01010101;
      tick();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      RS = 5'(i);
      RT = 5'(31 - i);
      tick();
      chk($sformatf("fill_rs%0d", i), d1[0], (i == 0) ? 32'd0 : 32'(i) * 32'h01010101);
      chk($sformatf("fill_rt%0d", 31 - i), d2[0], (i == 31) ? 32'd0 : 32'(31 - i) * 32'h01010101);
    end

    // Vector table: bypass and entry-zero cases.
    for (int k = 0; k < 6; k++) begin
      RS = tbl[k].rs;
      RT = tbl[k].rt;
      write_reg = tbl[k].wr;
      WriteData = tbl[k].wd;
      RegW = tbl[k].regw;
      #1;
      chk($sformatf("tbl%0d_byp_Data1", k), d1[0], tbl[k].e1);
      chk($sformatf("tbl%0d_byp_Data2", k), d2[0], tbl[k].e2);
      chk($sformatf("tbl%0d_nobyp_Data1", k), d1[1], tbl[k].n1);
      chk($sformatf("tbl%0d_nobyp_Data2", k), d2[1], tbl[k].n2);
      tick();
      if (k == 2) chkBit("r0_write_no_drop", drp[0], 1'b0);
      if (k == 3) chk("nozero_r0_value", d1[2], 32'hFFFFFFFF);
    end
    idle();

`ifdef REGFILE_SCOREBOARD_EN
    issue_valid = 1'b1;
    issue_reg = 5'd9;
    tick();
    issue_valid = 1'b0;
    RS = 5'd9;
    #1;
    chkBit("sb_issue_r9", rsP[0], 1'b1);
    tick();
    RegW = 1'b1;
    write_reg = 5'd9;
    WriteData = 32'h0BADF00D;
    issue_valid = 1'b1;
    issue_reg = 5'd9;
    tick();
    idle();
    #1;
    chkBit("sb_set_wins", rsP[0], 1'b1);
    tick();
    RegW = 1'b1;
    write_reg = 5'd9;
    #1;
    chkBit("sb_bypass_clear", rsP[0], 1'b0);
    chkBit("sb_nobypass_still_set", rsP[1], 1'b1);
    tick();
    idle();
    #1;
    chkBit("sb_cleared", rsP[1], 1'b0);
    tick();
`endif

    // Randomised traffic, including occasional resets.
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      write_reg = 5'($urandom_range(0, 31));
      RS = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      RT = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      WriteData = $urandom;
      RegW = ($urandom_range(0, 1) == 1);
`ifdef REGFILE_SCOREBOARD_EN
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_reg = ($urandom_range(0, 2) == 0) ? write_reg : 5'($urandom_range(0, 31));
`endif
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
